frv_pipeline_predecode: RTL and testbench
=========================================

Name: frv_pipeline_predecode

Overview:
- Sits directly downstream of fetch and consumes its s1_valid/s1_data/s1_error stream under the s1_busy back-pressure handshake.
- Attaches a program counter to each instruction, classifies it as 16 or 32 bit, and normalises the instruction word.
- Holds results in a 2-entry skid queue feeding the decode stage (s2).
- Registering s1_busy removes any combinational path from s2_busy back into fetch.

Parameters:
- FRV_PC_RESET_VALUE, 32'h8000_0000, PC of the first instruction after reset.
- XL, 31, MSB index of address/data buses.

Ports:
- g_clk  input  1  global clock
- g_reset  input  1  asynchronous active-high reset
- cf_req  input  1  control flow change request (same signal fetch sees)
- cf_ack  input  1  fetch acknowledge of cf_req
- cf_target  input  XL+1  control flow change target
- s1_valid  input  1  fetch holds a whole instruction
- s1_data  input  XL+1  instruction bits; [15:0] valid for 16-bit
- s1_error  input  1  fetch bus error for this instruction
- s1_busy  output  1  predecode cannot accept this cycle
- s2_valid  output  1  head entry valid
- s2_pc  output  XL+1  PC of head instruction
- s2_npc  output  XL+1  sequential next PC (pc+2 or pc+4)
- s2_instr  output  32  instruction; upper 16 bits zero for 16-bit
- s2_size  output  1  1 = 32-bit, 0 = 16-bit
- s2_error  output  1  fetch error flag
- s2_illegal  output  1  16-bit halfword equal to 0x0000
- s2_busy  input  1  decode stalls head

Behaviour:
- Clock and reset: clock g_clk; reset g_reset is asynchronous active-high. While asserted, clear:
  - queue count to 0,
  - pc register to FRV_PC_RESET_VALUE,
  - all storage to 0.
  Reset mid-operation discards all queued entries immediately.
- Output reset values: s2_valid=0, s1_busy=0, s2_pc=s2_npc=s2_instr=0, s2_size=s2_error=s2_illegal=0.
- cf_change = cf_req && cf_ack.
- accept = s1_valid && !s1_busy. Fetch eats 2/4 bytes on exactly this condition.
- Input that is accepted in the same cycle as cf_change is discarded: no enqueue, and the pc does not advance from it.
- s1_busy = (count == 2). Registered state only; no dependence on s2_busy or cf_req.
- Classification:
  - size32 = (s1_data[1:0] == 2'b11).
  - instr = size32 ? s1_data : {16'b0, s1_data[15:0]}.
  - illegal = !size32 && s1_data[15:0] == 0.
  - s1_error is stored as-is; classification applies unchanged when error is set.
- PC register, in priority order:
  1. cf_change: pc <= {cf_target[XL:1], 1'b0}.
  2. accept: pc <= pc + (size32 ? 4 : 2).
  3. Otherwise hold.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFE + 2 = 0x0000_0000.
- Entry on enqueue: {pc, pc+2/4, instr, size32, s1_error, illegal}. Latency is 1 cycle: accepted at edge N, visible on s2_* after edge N.
- Queue: 2 entries, in order.
  - s2_* always reflect entry 0 storage.
  - s2_valid = (count != 0).
  - Dequeue when s2_valid && !s2_busy.
  - Count transitions: enqueue only +1; dequeue only -1, shifting entry 1 to entry 0; both at count 1 means count stays 1 and entry 0 is loaded with new data.
  - Enqueue at count 2 cannot occur because s1_busy is asserted.
- cf_change flush: count <= 0 in the same edge. A dequeue in that cycle is still considered consumed by decode. Storage is not cleared.
- s2_* hold their values while s2_busy stalls, and remain stable until a dequeue.
- No combinational path from s1_* to s2_*.

Test Plan:
- Reset release, s1_data=0x00000013, s1_valid=1, s2_busy=0 → next cycle s2_valid=1, s2_pc=0x80000000, s2_npc=0x80000004, s2_size=1, s2_instr=0x00000013.
- Mixed stream 0x4501 (16-bit) then 0x00A00093 → s2_pc 0x80000000 (size0, instr 0x00004501), then 0x80000002 (npc 0x80000006).
- s2_busy=1 with continuous s1_valid → two entries accepted, s1_busy=1 from the third cycle, s2_* unchanged. Release s2_busy → entries drain in order, s1_busy drops the cycle after the first dequeue.
- cf_req=cf_ack=1, cf_target=0x80000102, with 2 entries queued and s1_valid=1 → s2_valid=0 next cycle, input dropped. Next accepted instruction has s2_pc=0x80000102.
- s1_data=0x0000, s1_error=1 → s2_illegal=1, s2_error=1, s2_size=0. PC 0xFFFFFFFC with 32-bit instruction → s2_npc=0x00000000.
- Assert g_reset asynchronously between edges with 2 entries queued → s2_valid and s1_busy drop immediately, without waiting for a clock edge. PC restarts at 0x80000000.

Source files
------------

// File: rtl/frv_pipeline_predecode_if.sv
`default_nettype none
// ============================================================================
// Module      : frv_pipeline_predecode_if
// Description : Bundles the fetch-side stream (s1), the decode-side stream
//               (s2) and the control-flow change signals around predecode.
//               'slave' is the predecode view, 'master' the surrounding
//               pipeline (fetch + decode) view.
// Revision    : 1.0 - initial release
// ============================================================================
interface frv_pipeline_predecode_if #(
  parameter int XL = 31
);

  // Control flow change, shared with fetch
  logic          cf_req;
  logic          cf_ack;
  logic [XL:0]   cf_target;

  // Fetch -> predecode
  logic          s1_valid;
  logic [XL:0]   s1_data;
  logic          s1_error;
  logic          s1_busy;

  // Predecode -> decode
  logic          s2_valid;
  logic [XL:0]   s2_pc;
  logic [XL:0]   s2_npc;
  logic [31:0]   s2_instr;
  logic          s2_size;
  logic          s2_error;
  logic          s2_illegal;
  logic          s2_busy;

  modport master (
    output cf_req, cf_ack, cf_target,
    output s1_valid, s1_data, s1_error,
    input  s1_busy,
    input  s2_valid, s2_pc, s2_npc, s2_instr, s2_size, s2_error, s2_illegal,
    output s2_busy
  );

  modport slave (
    input  cf_req, cf_ack, cf_target,
    input  s1_valid, s1_data, s1_error,
    output s1_busy,
    output s2_valid, s2_pc, s2_npc, s2_instr, s2_size, s2_error, s2_illegal,
    input  s2_busy
  );

endinterface
`default_nettype wire

// File: rtl/frv_pipeline_predecode.sv
`default_nettype none
// ============================================================================
// Module      : frv_pipeline_predecode
// Description : Predecode stage between fetch (s1) and decode (s2). Tags each
//               instruction with its PC and sequential next PC, classifies it
//               as 16/32 bit, zero-extends compressed encodings and buffers
//               results in a 2-entry in-order skid queue. s1_busy comes from
//               registered occupancy only, so decode stalls never reach
//               fetch combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module frv_pipeline_predecode #(
  parameter logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000,
  parameter int          XL                 = 31
) (
  input  wire logic               g_clk,
  input  wire logic               g_reset,
  frv_pipeline_predecode_if.slave bus
);

  typedef struct packed {
    logic [XL:0] pc;
    logic [XL:0] npc;
    logic [31:0] instr;
    logic        size;
    logic        err;
    logic        ill;
  } entry_t;

  localparam logic [1:0]  c_CNT_EMPTY = 2'd0;
  localparam logic [1:0]  c_CNT_ONE   = 2'd1;
  localparam logic [1:0]  c_CNT_FULL  = 2'd2;
  localparam logic [XL:0] c_INC2      = (XL+1)'(2);
  localparam logic [XL:0] c_INC4      = (XL+1)'(4);

  logic [1:0]  r_count;
  logic [XL:0] r_pc;
  entry_t      r_e0;
  entry_t      r_e1;

  logic        w_cf_change;
  logic        w_accept;
  logic        w_enq;
  logic        w_deq;
  logic        w_size32;
  logic [XL:0] w_seq_npc;
  entry_t      w_new;
  logic [1:0]  w_count_nxt;
  logic [XL:0] w_pc_nxt;
  entry_t      w_e0_nxt;
  entry_t      w_e1_nxt;

  // Handshake decode: an accept that coincides with a redirect is dropped
  always_comb begin
    w_cf_change = bus.cf_req && bus.cf_ack;
    w_accept    = bus.s1_valid && !bus.s1_busy;
    w_enq       = w_accept && !w_cf_change;
    w_deq       = bus.s2_valid && !bus.s2_busy;
  end

  // Classify the incoming word and build the entry it would become
  always_comb begin
    w_size32     = (bus.s1_data[1:0] == 2'b11);
    w_seq_npc    = r_pc + (w_size32 ? c_INC4 : c_INC2);
    w_new.pc     = r_pc;
    w_new.npc    = w_seq_npc;
    w_new.instr  = w_size32 ? bus.s1_data[31:0] : {16'b0, bus.s1_data[15:0]};
    w_new.size   = w_size32;
    w_new.err    = bus.s1_error;
    w_new.ill    = !w_size32 && (bus.s1_data[15:0] == 16'h0000);
  end

  // Queue occupancy: a redirect empties the queue regardless of traffic
  always_comb begin
    w_count_nxt = r_count;
    if (w_cf_change) begin
      w_count_nxt = c_CNT_EMPTY;
    end else begin
      case ({w_enq, w_deq})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Storage update: shift on dequeue, new data lands in the first free slot
  always_comb begin
    w_e0_nxt = r_e0;
    w_e1_nxt = r_e1;
    if (w_deq) begin
      w_e0_nxt = r_e1;
    end
    if (w_enq) begin
      if ((r_count == c_CNT_EMPTY) || ((r_count == c_CNT_ONE) && w_deq)) begin
        w_e0_nxt = w_new;
      end else begin
        w_e1_nxt = w_new;
      end
    end
  end

  // Program counter: redirect wins over sequential advance
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_cf_change) begin
      w_pc_nxt = {bus.cf_target[XL:1], 1'b0};
    end else if (w_accept) begin
      w_pc_nxt = w_seq_npc;
    end
  end

  // State registers, cleared asynchronously so reset drops outputs at once
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_count <= c_CNT_EMPTY;
      r_pc    <= FRV_PC_RESET_VALUE[XL:0];
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_pc    <= w_pc_nxt;
      r_e0    <= w_e0_nxt;
      r_e1    <= w_e1_nxt;
    end
  end

  // Outputs come straight from registered state
  always_comb begin
    bus.s1_busy    = (r_count == c_CNT_FULL);
    bus.s2_valid   = (r_count != c_CNT_EMPTY);
    bus.s2_pc      = r_e0.pc;
    bus.s2_npc     = r_e0.npc;
    bus.s2_instr   = r_e0.instr;
    bus.s2_size    = r_e0.size;
    bus.s2_error   = r_e0.err;
    bus.s2_illegal = r_e0.ill;
  end

endmodule
`default_nettype wire

// File: tb/tb_frv_pipeline_predecode.sv
`default_nettype none
// ============================================================================
// Module      : tb_frv_pipeline_predecode
// Description : Scoreboard bench for frv_pipeline_predecode. The driver keeps
//               a behavioural model (PC + list of pending instructions) and
//               queues expected entries; a monitor compares the queue head
//               with s2_* every cycle and retires it on dequeue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frv_pipeline_predecode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        size;
    logic        err;
    logic        ill;
  } ent_t;

  logic g_clk = 1'b0;
  logic g_reset;

  always #5 g_clk = ~g_clk;

  frv_pipeline_predecode_if #(.XL(31)) bus ();

  frv_pipeline_predecode #(
    .FRV_PC_RESET_VALUE (32'h8000_0000),
    .XL                 (31)
  ) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  int          checks = 0;
  int          errors = 0;
  ent_t        sb[$];
  logic        pend_push  = 1'b0;
  logic        pend_flush = 1'b0;
  ent_t        pend_ent;
  logic [31:0] m_pc;

  task automatic chk(input string nm, input logic [98:0] act, input logic [98:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected entry straight from the instruction-format rules
  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] d, input logic e);
    ent_t r;
    r.size  = (d[1:0] == 2'b11);
    r.pc    = pc;
    r.npc   = pc + (r.size ? 32'd4 : 32'd2);
    r.instr = r.size ? d : {16'h0000, d[15:0]};
    r.err   = e;
    r.ill   = !r.size && (d[15:0] == 16'h0000);
    return r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       r[1:0] = 2'b11;
      1:       r[15:0] = 16'h0000;
      default: if (r[1:0] == 2'b11) r[0] = 1'b0;
    endcase
    return r;
  endfunction

  // One cycle of stimulus; model decides acceptance from its own occupancy
  task automatic cyc(input logic v, input logic [31:0] d, input logic e,
                     input logic cr, input logic ca, input logic [31:0] tg,
                     input logic busy);
    logic acc;
    @(negedge g_clk);
    #1;
    bus.s1_valid  = v;
    bus.s1_data   = d;
    bus.s1_error  = e;
    bus.cf_req    = cr;
    bus.cf_ack    = ca;
    bus.cf_target = tg;
    bus.s2_busy   = busy;
    if (!g_reset) begin
      acc = v && (sb.size() != 2);
      if (cr && ca) begin
        pend_flush = 1'b1;
        m_pc       = {tg[31:1], 1'b0};
      end else if (acc) begin
        pend_ent  = mk(m_pc, d, e);
        pend_push = 1'b1;
        m_pc      = pend_ent.npc;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compares just before each rising edge, then applies the cycle
  initial begin
    ent_t act;
    forever begin
      @(negedge g_clk);
      #2;
      if (!g_reset) begin
        chk("s1_busy", 99'(bus.s1_busy), 99'(sb.size() == 2));
        chk("s2_valid", 99'(bus.s2_valid), 99'(sb.size() != 0));
        if (sb.size() != 0) begin
          act = {bus.s2_pc, bus.s2_npc, bus.s2_instr, bus.s2_size, bus.s2_error, bus.s2_illegal};
          chk("s2_head", act, sb[0]);
          if (!bus.s2_busy) void'(sb.pop_front());
        end
        if (pend_flush) sb.delete();
        else if (pend_push) sb.push_back(pend_ent);
        pend_push  = 1'b0;
        pend_flush = 1'b0;
      end
    end
  end

  initial begin
    g_reset       = 1'b1;
    bus.s1_valid  = 1'b0;
    bus.s1_data   = '0;
    bus.s1_error  = 1'b0;
    bus.cf_req    = 1'b0;
    bus.cf_ack    = 1'b0;
    bus.cf_target = '0;
    bus.s2_busy   = 1'b0;
    m_pc          = 32'h8000_0000;

    // Reset state
    repeat (2) @(negedge g_clk);
    #1;
    chk("rst_s2_valid", 99'(bus.s2_valid), 99'(0));
    chk("rst_s1_busy", 99'(bus.s1_busy), 99'(0));
    chk("rst_s2_fields",
        {bus.s2_pc, bus.s2_npc, bus.s2_instr, bus.s2_size, bus.s2_error, bus.s2_illegal}, 99'(0));
    g_reset = 1'b0;

    // First instruction after reset
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2);

    // Mixed 16/32-bit stream
    cyc(1'b1, 32'h0000_4501, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h00A0_0093, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2);

    // Decode stall fills the queue, then drains in order
    for (int i = 0; i < 4; i++) cyc(1'b1, rnd_instr(), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect with a full queue and input pending
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_instr(), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 32'h8000_0102, 1'b1);
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2);

    // Error on an all-zero halfword, then PC wrap at the top of memory
    cyc(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0);
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h0000_4501, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2);

    // Asynchronous reset between edges with the queue full
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_instr(), 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge g_clk);
    #3;
    g_reset = 1'b1;
    #1;
    chk("arst_s2_valid", 99'(bus.s2_valid), 99'(0));
    chk("arst_s1_busy", 99'(bus.s1_busy), 99'(0));
    sb.delete();
    pend_push    = 1'b0;
    pend_flush   = 1'b0;
    m_pc         = 32'h8000_0000;
    bus.s1_valid = 1'b0;
    bus.cf_req   = 1'b0;
    @(negedge g_clk);
    #1;
    g_reset = 1'b0;
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 7) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom,
          $urandom_range(0, 2) == 0);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
